sram_arbiter: RTL

- Round-robin arbiter and access sequencer that shares the single byte-wide SRAM connection between N_REQ requesters, e.g. cores and the loader.
- Latches one request at a time and drives the SRAM connection's write/read/byte_en/addr/data_in strobes for a fixed number of cycles.
- Captures the read byte and returns it to the winner with a one-cycle ack.
- Sits between the requesters and the SRAM connection block.

---
 rtl/sram_arbiter_pkg.sv | 29 ++
 rtl/sram_arbiter_rr_pick.sv | 39 +++
 rtl/sram_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding,
// default widths/strobe lengths and small helpers.
package sram_arbiter_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 8;
    localparam int WR_CYCLES_DEF = 2;
    localparam int RD_CYCLES_DEF = 2;

    localparam logic [1:0] BE_NONE  = 2'b00;
    localparam logic [1:0] BE_LANE0 = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or
// after the pointer, wrapping from the top requester to 0.
module sram_arbiter_rr_pick
    import sram_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IDX_W'(j);
            if (!any_valid && req[jj]) begin
                any_valid = 1'b1;
                idx       = jj;
                gnt[jj]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one byte-wide
// SRAM port between N_REQ requesters; one access at a time.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [1:0]              mem_byte_en,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(max_int(WR_CYCLES, RD_CYCLES) + 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             wr_last;
    logic             rd_last;

    sram_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr),
        .gnt       (pick_gnt),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    assign ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0
                                                      : pick_idx + IDX_W'(1);
    assign wr_last  = (cnt == CNT_W'(WR_CYCLES - 1));
    assign rd_last  = (cnt == CNT_W'(RD_CYCLES - 1));

    // mem_addr/mem_wdata/gnt double as the request latch, so input
    // changes after the grant edge cannot reach the SRAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ack         <= '0;
            rdata       <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_byte_en <= BE_NONE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (pick_any) begin
                        gnt         <= pick_gnt;
                        ptr         <= ptr_next;
                        busy        <= 1'b1;
                        mem_byte_en <= BE_LANE0;
                        mem_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        if (req_we[pick_idx]) begin
                            state     <= S_WR;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        end else begin
                            state    <= S_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (wr_last) begin
                        state       <= S_RESP;
                        cnt         <= '0;
                        ack         <= gnt;
                        rdata       <= '0;
                        mem_write   <= 1'b0;
                        mem_byte_en <= BE_NONE;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RD: begin
                    if (rd_last) begin
                        state       <= S_RESP;
                        cnt         <= '0;
                        ack         <= gnt;
                        rdata       <= mem_rdata;
                        mem_read    <= 1'b0;
                        mem_byte_en <= BE_NONE;
                        mem_addr    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ack   <= '0;
                    gnt   <= '0;
                    rdata <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
